scmp_bus_if: RTL
================

# scmp_bus_if

Parametrised external bus-cycle sequencer for the SC/MP core family. It takes single read/write requests from the core's microcode bus controls and turns them into the multiplexed SC/MP bus protocol. That protocol covers the address phase with the status/high-address byte on the data pins, RD/WR strobes, HOLD wait-state extension and ENIN/ENOUT/BREQ daisy-chain arbitration. This unit generalises the fixed-timing strobe generation inside the current core: address width, phase lengths and a hold timeout are now parameters.

## Interface
- ADDR_W, 16, core-side logical address width.
- PIN_ADDR_W, 12, address pins driven; ADDR_W-PIN_ADDR_W must equal DATA_W-4.
- DATA_W, 8, data bus width.
- ADS_CYC, 1, address-strobe cycles (>=1).
- STB_CYC, 2, minimum RD/WR strobe cycles (>=1).
- REC_CYC, 1, recovery cycles after strobe (>=1).
- TMO_CYC, 0, maximum extra HOLD cycles before abort; 0 disables timeout.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  core request; held stable until ready.
- we  in  1  1=write, 0=read; sampled with req.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  write data.
- flags  in  4  {F_H,F_D,F_I,F_R} status flags for this cycle.
- ready  out  1  one-cycle completion pulse.
- err  out  1  high with ready when the cycle was aborted by timeout.
- rdata  out  DATA_W  read data, valid from ready until next accepted read.
- bus_addr  out  PIN_ADDR_W  address pins.
- D_i  in  DATA_W  data pins in.
- D_o  out  DATA_W  data pins out.
- D_oe  out  1  data pin output enable.
- ADS_n, RD_n, WR_n  out  1 each  bus strobes.
- hold_n  in  1  low extends strobe.
- enin  in  1  bus enable in (daisy chain).
- breq_i  in  1  bus request sensed (another master owns the bus).
- breq_o  out  1  this unit owns/requests the bus.
- enout  out  1  bus enable out to next master.

## Operation
- States: IDLE, ADDR, STRB, REC.
- IDLE: accept when req & ~ready & enin & ~breq_i. On acceptance, latch we/addr/wdata/flags, go to ADDR and load the phase counter.
- ADDR, for ADS_CYC cycles:
  - ADS_n=0, D_oe=1, D_o={flags, addr[ADDR_W-1:PIN_ADDR_W]}.
  - bus_addr=addr[PIN_ADDR_W-1:0].
- STRB: RD_n=0 for a read, or WR_n=0 with D_oe=1 and D_o=wdata for a write.
  - Exit when the STB_CYC counter is exhausted and hold_n=1 is sampled at that edge.
  - While exhausted and hold_n=0, count extra cycles. If TMO_CYC!=0 and the extra cycles reach TMO_CYC, exit with the abort flag set.
  - Read: rdata <= D_i on the exit edge; rdata <= all-ones on abort.
- REC, for REC_CYC cycles: strobes high, D_oe=0, bus_addr held. Then go to IDLE with ready=1 (and err=abort) for one cycle.
- breq_o=1 from the acceptance edge through the end of REC; 0 in IDLE.
- enout = enin & ~breq_o & ~(req & ~ready), combinational. A master that wants the bus blocks downstream.
- req dropping mid-cycle is ignored; the cycle completes.
- A new request cannot be accepted in the ready cycle. Back-to-back requests are therefore separated by at least one IDLE cycle and re-arbitrate.
- Reset (async, any state) immediately gives:
  - state=IDLE.
  - ADS_n=RD_n=WR_n=1.
  - D_oe=0, D_o=0, bus_addr=0.
  - breq_o=0, ready=0, err=0, rdata=0.
  - enout follows enin & ~req.

## Timing
- All outputs except enout are registered from state.
- Request sampled at edge E0 in IDLE:
  - ADS_n low in cycles 1..ADS_CYC.
  - Strobe low for the next STB_CYC+H cycles, where H is the number of hold-extension cycles.
  - Recovery for REC_CYC cycles.
  - ready in the cycle after that.
- Default latency: E0 to ready = ADS_CYC+STB_CYC+REC_CYC+1 = 5 cycles, +H.
- bus_addr is stable from the first ADDR cycle through the last REC cycle.
- D_o/D_oe change only on phase boundaries; D_oe is never high in REC or IDLE.

## Test plan
- Default params, read addr=0xA123, flags=4'b1001, D_i=0x5C during strobe:
  - ADS_n low 1 cycle with D_o=0x9A and bus_addr=0x123.
  - RD_n low 2 cycles.
  - ready 5 cycles after acceptance, rdata=0x5C, err=0.
- Write addr=0x0FFF, wdata=0x3E, hold_n low for 3 strobe cycles:
  - WR_n low for 5 cycles with D_o=0x3E, D_oe=1.
  - ready at cycle 8.
- Arbitration:
  - enin=0 holds the request in IDLE and enout=0.
  - breq_i=1 with enin=1 also stalls.
  - When both clear, the request is accepted the next edge.
  - Idle with req=0 gives enout=enin.
- TMO_CYC=4, read with hold_n stuck low:
  - RD_n low for STB_CYC+4 cycles.
  - ready=1, err=1, rdata=0xFF.
- Async reset asserted mid-STRB of a write:
  - All strobes high and D_oe=0 immediately.
  - breq_o=0, no ready pulse.
  - After release, a new read completes normally.
- ADS_CYC=2, STB_CYC=3, REC_CYC=2, req held through ready:
  - ready at cycle 8, single pulse.
  - Second request accepted no earlier than the cycle after ready.

Source files
------------

// File: rtl/scmp_bus_if.sv
// rtl/scmp_bus_if.sv - SC/MP external bus-cycle sequencer
// Turns single core read/write requests into multiplexed SC/MP bus cycles with HOLD and daisy-chain arbitration.
module scmp_bus_if #(
  parameter int ADDR_W     = 16,
  parameter int PIN_ADDR_W = 12,
  parameter int DATA_W     = 8,
  parameter int ADS_CYC    = 1,
  parameter int STB_CYC    = 2,
  parameter int REC_CYC    = 1,
  parameter int TMO_CYC    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [3:0]            flags,
  output logic                  ready,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic [PIN_ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0]     D_i,
  output logic [DATA_W-1:0]     D_o,
  output logic                  D_oe,
  output logic                  ADS_n,
  output logic                  RD_n,
  output logic                  WR_n,
  input  logic                  hold_n,
  input  logic                  enin,
  input  logic                  breq_i,
  output logic                  breq_o,
  output logic                  enout
);

  localparam int MAX_AS = (ADS_CYC > STB_CYC) ? ADS_CYC : STB_CYC;
  localparam int MAX_C  = (MAX_AS > REC_CYC) ? MAX_AS : REC_CYC;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int EXT_W  = $clog2(TMO_CYC + 2);
  localparam logic [CNT_W-1:0] ADS_LD = CNT_W'(ADS_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LD = CNT_W'(STB_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LD = CNT_W'(REC_CYC - 1);
  localparam logic [EXT_W-1:0] TMO_V  = EXT_W'(TMO_CYC);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STRB, S_REC} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EXT_W-1:0]      ext_q, ext_d;
  logic                  abort_q, abort_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [3:0]            flags_q, flags_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  ads_n_q, ads_n_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  d_oe_q, d_oe_d;
  logic [DATA_W-1:0]     d_o_q, d_o_d;
  logic [PIN_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic                  breq_q, breq_d;
  logic                  accept;

  assign accept = (state_q == S_IDLE) & req & ~ready_q & enin & ~breq_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    abort_d = abort_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    flags_d = flags_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          flags_d = flags;
          abort_d = 1'b0;
          ext_d   = '0;
          cnt_d   = ADS_LD;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) begin
          cnt_d   = STB_LD;
          state_d = S_STRB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STRB: begin
        // Minimum strobe first, then HOLD extension with optional abort
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (hold_n) begin
          cnt_d   = REC_LD;
          state_d = S_REC;
          if (!we_q) rdata_d = D_i;
        end else if ((TMO_CYC != 0) && (ext_q == TMO_V)) begin
          cnt_d   = REC_LD;
          state_d = S_REC;
          abort_d = 1'b1;
          if (!we_q) rdata_d = '1;
        end else begin
          ext_d = ext_q + EXT_W'(1);
        end
      end
      S_REC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          err_d   = abort_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values for the coming cycle follow the next state
    ads_n_d    = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    d_oe_d     = 1'b0;
    d_o_d      = '0;
    bus_addr_d = bus_addr_q;
    breq_d     = (state_d != S_IDLE);
    case (state_d)
      S_ADDR: begin
        ads_n_d    = 1'b0;
        d_oe_d     = 1'b1;
        d_o_d      = {flags_d, addr_d[ADDR_W-1:PIN_ADDR_W]};
        bus_addr_d = addr_d[PIN_ADDR_W-1:0];
      end
      S_STRB: begin
        if (we_d) begin
          wr_n_d = 1'b0;
          d_oe_d = 1'b1;
          d_o_d  = wdata_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ext_q      <= '0;
      abort_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      flags_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      ads_n_q    <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      d_oe_q     <= 1'b0;
      d_o_q      <= '0;
      bus_addr_q <= '0;
      breq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      abort_q    <= abort_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      flags_q    <= flags_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      ads_n_q    <= ads_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      d_oe_q     <= d_oe_d;
      d_o_q      <= d_o_d;
      bus_addr_q <= bus_addr_d;
      breq_q     <= breq_d;
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign bus_addr = bus_addr_q;
  assign D_o      = d_o_q;
  assign D_oe     = d_oe_q;
  assign ADS_n    = ads_n_q;
  assign RD_n     = rd_n_q;
  assign WR_n     = wr_n_q;
  assign breq_o   = breq_q;
  // A pending request of our own blocks the chain even before acceptance
  assign enout    = enin & ~breq_q & ~(req & ~ready_q);

endmodule
